// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: five-stage pipeline stall/flush control for load-use hazards, taken branches and data-memory waits
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1_i,
  input  logic [4:0]  id_rs2_i,
  input  logic [4:0]  id_ex_rd_i,
  input  logic        id_ex_mem_read_i,
  input  logic        ex_branch_taken_i,
  input  logic        dmem_req_i,
  input  logic        dmem_ready_i,
  output logic        pc_en_o,
  output logic        if_id_en_o,
  output logic        id_ex_en_o,
  output logic        ex_mem_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        mem_wb_bubble_o,
  output logic        mem_err_o,
  output logic [15:0] stall_cycles_o,
  output logic [1:0]  state_o
);
  typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, ERROR = 2'b10} state_e;
  state_e      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic        err_q, err_d;
  logic [15:0] stall_q, stall_d;
  logic        lu, mm, run, mwait, hold, dec, br, lus;
  // Hazard detection and the stage-control decode; a completing MEM_WAIT reuses the RUN decode so pending work is serviced immediately
  always_comb begin
    lu    = id_ex_mem_read_i & (id_ex_rd_i != 5'd0) & (id_ex_rd_i == id_rs1_i | id_ex_rd_i == id_rs2_i);
    mm    = dmem_req_i & ~dmem_ready_i;
    run   = state_q == RUN;
    mwait = state_q == MEM_WAIT;
    hold  = (run & mm) | (mwait & ~dmem_ready_i) | (state_q == ERROR);
    dec   = (run & ~mm) | (mwait & dmem_ready_i);
    br    = dec & ex_branch_taken_i;
    lus   = dec & ~ex_branch_taken_i & lu;
    pc_en_o         = ~hold & ~lus;
    if_id_en_o      = ~hold & ~lus;
    id_ex_en_o      = ~hold;
    ex_mem_en_o     = ~hold;
    if_id_flush_o   = br;
    id_ex_flush_o   = br | lus;
    mem_wb_bubble_o = hold;
    mem_err_o       = err_q;
    stall_cycles_o  = stall_q;
    state_o         = state_q;
  end
  // Next-state logic: ready beats timeout, ERROR is left only through reset
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    if (run && mm) begin
      state_d = MEM_WAIT;
      wait_d  = 8'd1;
    end else if (mwait) begin
      state_d = dmem_ready_i ? RUN : (wait_q == 8'(MEM_TIMEOUT)) ? ERROR : MEM_WAIT;
      wait_d  = dmem_ready_i ? 8'd0 : wait_q + 8'd1;
    end
    err_d   = err_q | (state_d == ERROR);
    stall_d = (!pc_en_o && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
  end
  // State, wait counter, sticky error and saturating stall counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      err_q   <= 1'b0;
      stall_q <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  logic clk = 1'b0, reset = 1'b1;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic mr = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, bub, err;
  logic [15:0] sc;
  logic [1:0] st;
  logic b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_if_id_flush, b_id_ex_flush, b_bub, b_err;
  logic [15:0] b_sc;
  logic [1:0] b_st;
  int vectors = 0, miscompares = 0;
  typedef struct packed {logic [7:0] o; logic [1:0] st; logic [15:0] sc;} exp_t;
  exp_t q[$];
  exp_t e;
  localparam logic [7:0] RUN_OK = 8'b1111_0000, MM = 8'b0000_0010, BR = 8'b1111_1100,
                         LU = 8'b0011_0100, ERR = 8'b0000_0011;
  wire [7:0] o = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, bub, err};
  always #5 clk = ~clk;
  pipe_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .id_rs1_i(rs1), .id_rs2_i(rs2), .id_ex_rd_i(rd),
    .id_ex_mem_read_i(mr), .ex_branch_taken_i(br), .dmem_req_i(req), .dmem_ready_i(rdy),
    .pc_en_o(pc_en), .if_id_en_o(if_id_en), .id_ex_en_o(id_ex_en), .ex_mem_en_o(ex_mem_en),
    .if_id_flush_o(if_id_flush), .id_ex_flush_o(id_ex_flush), .mem_wb_bubble_o(bub),
    .mem_err_o(err), .stall_cycles_o(sc), .state_o(st));
  pipe_hazard_ctrl #(.MEM_TIMEOUT(255)) dut_big (
    .clk(clk), .reset(reset), .id_rs1_i(rs1), .id_rs2_i(rs2), .id_ex_rd_i(rd),
    .id_ex_mem_read_i(mr), .ex_branch_taken_i(br), .dmem_req_i(req), .dmem_ready_i(rdy),
    .pc_en_o(b_pc_en), .if_id_en_o(b_if_id_en), .id_ex_en_o(b_id_ex_en), .ex_mem_en_o(b_ex_mem_en),
    .if_id_flush_o(b_if_id_flush), .id_ex_flush_o(b_id_ex_flush), .mem_wb_bubble_o(b_bub),
    .mem_err_o(b_err), .stall_cycles_o(b_sc), .state_o(b_st));
  task automatic chk(input string tag, input logic [15:0] a, input logic [15:0] x);
    vectors++;
    assert (a === x) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, a, x);
    end
  endtask
  task automatic step(input string tag, input logic [4:0] s1, s2, d, input logic m, b, r, y,
                      input logic [7:0] eo, input logic [1:0] es, input logic [15:0] esc);
    @(posedge clk);
    #1;
    rs1 = s1; rs2 = s2; rd = d; mr = m; br = b; req = r; rdy = y;
    q.push_back('{eo, es, esc});
    @(negedge clk);
    e = q.pop_front();
    chk({tag, ".out"}, 16'(o), 16'(e.o));
    chk({tag, ".state"}, 16'(st), 16'(e.st));
    chk({tag, ".stall"}, sc, e.sc);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1; rs1 = '0; rs2 = '0; rd = '0; mr = 0; br = 0; req = 0; rdy = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    step("reset_idle", 0, 0, 0, 0, 0, 0, 0, RUN_OK, 2'd0, 16'd0);
    step("x0_load",    0, 0, 0, 1, 0, 0, 0, RUN_OK, 2'd0, 16'd0);
    step("x0_after",   0, 0, 0, 0, 0, 0, 0, RUN_OK, 2'd0, 16'd0);
    step("lu_rs2",     0, 5, 5, 1, 0, 0, 0, LU,     2'd0, 16'd0);
    step("lu_rs2_end", 0, 0, 0, 0, 0, 0, 0, RUN_OK, 2'd0, 16'd1);
    step("lu_rs1",     7, 0, 7, 1, 0, 0, 0, LU,     2'd0, 16'd1);
    step("no_load",    7, 0, 7, 0, 0, 0, 0, RUN_OK, 2'd0, 16'd2);
    step("br_and_lu",  7, 0, 7, 1, 1, 0, 0, BR,     2'd0, 16'd2);
    step("mw_1",       0, 0, 0, 0, 0, 1, 0, MM,     2'd0, 16'd2);
    step("mw_2",       0, 0, 0, 0, 0, 1, 0, MM,     2'd1, 16'd3);
    step("mw_3",       0, 0, 0, 0, 0, 1, 0, MM,     2'd1, 16'd4);
    step("mw_ready",   0, 0, 0, 0, 0, 1, 1, RUN_OK, 2'd1, 16'd5);
    step("mw_back",    0, 0, 0, 0, 0, 0, 0, RUN_OK, 2'd0, 16'd5);
    step("mwbr_1",     0, 0, 0, 0, 1, 1, 0, MM,     2'd0, 16'd5);
    step("mwbr_2",     0, 0, 0, 0, 1, 1, 0, MM,     2'd1, 16'd6);
    step("mwbr_rdy",   0, 0, 0, 0, 1, 1, 1, BR,     2'd1, 16'd7);
    step("mwbr_back",  0, 0, 0, 0, 0, 0, 0, RUN_OK, 2'd0, 16'd7);
    step("mwlu_1",     0, 0, 0, 0, 0, 1, 0, MM,     2'd0, 16'd7);
    step("mwlu_rdy",   5, 0, 5, 1, 0, 1, 1, LU,     2'd1, 16'd8);
    step("mwlu_back",  0, 0, 0, 0, 0, 0, 0, RUN_OK, 2'd0, 16'd9);
    step("to_rdy_1",   0, 0, 0, 0, 1, 1, 0, MM,     2'd0, 16'd9);
    step("to_rdy_2",   0, 0, 0, 0, 0, 1, 0, MM,     2'd1, 16'd10);
    step("to_rdy_3",   0, 0, 0, 0, 0, 1, 0, MM,     2'd1, 16'd11);
    step("to_rdy_4",   0, 0, 0, 0, 0, 1, 0, MM,     2'd1, 16'd12);
    step("to_rdy_win", 0, 0, 0, 0, 0, 1, 1, RUN_OK, 2'd1, 16'd13);
    step("to_rdy_run", 0, 0, 0, 0, 0, 0, 0, RUN_OK, 2'd0, 16'd13);
    step("to_1",       0, 0, 0, 0, 0, 1, 0, MM,     2'd0, 16'd13);
    step("to_2",       0, 0, 0, 0, 0, 1, 0, MM,     2'd1, 16'd14);
    step("to_3",       0, 0, 0, 0, 0, 1, 0, MM,     2'd1, 16'd15);
    step("to_4",       0, 0, 0, 0, 0, 1, 0, MM,     2'd1, 16'd16);
    step("to_5",       0, 0, 0, 0, 0, 1, 0, MM,     2'd1, 16'd17);
    step("err_hold",   0, 0, 0, 0, 0, 0, 0, ERR,    2'd2, 16'd18);
    step("err_sticky", 5, 0, 5, 1, 1, 1, 1, ERR,    2'd2, 16'd19);
    do_reset();
    step("rst_clear",  0, 0, 0, 0, 0, 0, 0, RUN_OK, 2'd0, 16'd0);
    do_reset();
    req = 1'b1;
    repeat (65534) @(posedge clk);
    q.push_back('{ERR, 2'd2, 16'hFFFE});
    @(negedge clk);
    e = q.pop_front();
    chk("sat_below", b_sc, e.sc);
    chk("sat_err_out", 16'(o), 16'(e.o));
    @(posedge clk);
    q.push_back('{ERR, 2'd2, 16'hFFFF});
    @(negedge clk);
    e = q.pop_front();
    chk("sat_reach", b_sc, e.sc);
    repeat (4465) @(posedge clk);
    q.push_back('{ERR, 2'd2, 16'hFFFF});
    @(negedge clk);
    e = q.pop_front();
    chk("sat_hold_big", b_sc, e.sc);
    chk("sat_hold", sc, e.sc);
    chk("sat_state", 16'(st), 16'(e.st));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
